// File: rtl/wb_regbank_pkg.sv
`default_nettype none
// ============================================================================
// wb_regbank_pkg : shared constants and helpers for the Wishbone register bank
// Rev 1.0
// ============================================================================
package wb_regbank_pkg;

    localparam int   WB_DW      = 32;
    localparam logic CTRL_OFS   = 1'b0;
    localparam logic STATUS_OFS = 1'b1;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res++;
        end
        return res;
    endfunction

    function automatic logic [WB_DW-1:0] byte_merge(
        input logic [WB_DW-1:0]   old_word,
        input logic [WB_DW-1:0]   new_word,
        input logic [WB_DW/8-1:0] sel
    );
        logic [WB_DW-1:0] res;
        res = old_word;
        for (int b = 0; b < WB_DW/8; b++) begin
            if (sel[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_slave_frontend.sv
`default_nettype none
// ============================================================================
// wb_slave_frontend : Wishbone request tracking, write pipeline and termination
// Rev 1.0
// ============================================================================
module wb_slave_frontend
    import wb_regbank_pkg::*;
#(
    parameter int ADR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cyc,
    input  logic             stb,
    input  logic             we,
    input  logic [ADR_W-1:0] adr,
    input  logic [3:0]       sel,
    input  logic [WB_DW-1:0] wdata,
    input  logic             rd_hit,
    input  logic [WB_DW-1:0] rd_word,
    input  logic             wr_hit,
    output logic             rd_req,
    output logic             wr_pend,
    output logic [ADR_W-1:0] wr_adr,
    output logic [3:0]       wr_sel,
    output logic [WB_DW-1:0] wr_data,
    output logic             ack,
    output logic             err,
    output logic             stall,
    output logic [WB_DW-1:0] rdata
);

    logic en;
    logic wr_req;
    logic rip;
    logic wip;
    logic rd_ack;
    logic rd_err;

    assign en     = cyc & stb;
    assign rd_req = en & ~we & ~rip;
    assign wr_req = en & we & ~wip;

    // rip/wip stay high through the termination cycle so a strobe still held
    // there is not taken as a second request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rip     <= 1'b0;
            wip     <= 1'b0;
            rd_ack  <= 1'b0;
            rd_err  <= 1'b0;
            rdata   <= '0;
            wr_pend <= 1'b0;
            wr_adr  <= '0;
            wr_sel  <= '0;
            wr_data <= '0;
        end else begin
            rip     <= rd_req | (rip & ~(rd_ack | rd_err));
            wip     <= wr_req | (wip & ~wr_pend);
            rd_ack  <= rd_req & rd_hit;
            rd_err  <= rd_req & ~rd_hit;
            wr_pend <= wr_req;
            if (rd_req) begin
                rdata <= rd_hit ? rd_word : '0;
            end
            if (wr_req) begin
                wr_adr  <= adr;
                wr_sel  <= sel;
                wr_data <= wdata;
            end
        end
    end

    assign ack   = rd_ack | (wr_pend & wr_hit);
    assign err   = rd_err | (wr_pend & ~wr_hit);
    assign stall = ~(ack | err) & en;

endmodule
`default_nettype wire

// File: rtl/wb_repeat_regbank.sv
`default_nettype none
// ============================================================================
// wb_repeat_regbank : Wishbone bank of NUM_CH ctrl (RW) / status (RO) channels
// Rev 1.0
// ============================================================================
module wb_repeat_regbank
    import wb_regbank_pkg::*;
#(
    parameter int          NUM_CH   = 4,
    parameter int          CTRL_W   = 32,
    parameter logic [31:0] CTRL_RST = 32'h0
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic [clog2(NUM_CH)+2:2]   wb_adr_i,
    input  logic [3:0]                 wb_sel_i,
    input  logic                       wb_we_i,
    input  logic [WB_DW-1:0]           wb_dat_i,
    output logic                       wb_ack_o,
    output logic                       wb_err_o,
    output logic                       wb_rty_o,
    output logic                       wb_stall_o,
    output logic [WB_DW-1:0]           wb_dat_o,
    output logic [NUM_CH*CTRL_W-1:0]   ctrl_o,
    output logic [NUM_CH-1:0]          ctrl_wr_o,
    input  logic [NUM_CH*WB_DW-1:0]    status_i
);

    localparam int ADR_W = clog2(NUM_CH) + 1;
    localparam int CH_W  = (ADR_W > 1) ? ADR_W - 1 : 1;

    logic             rd_req;
    logic             wr_pend;
    logic [ADR_W-1:0] wr_adr;
    logic [3:0]       wr_sel;
    logic [WB_DW-1:0] wr_data;
    logic             rd_hit;
    logic             wr_hit;
    logic [WB_DW-1:0] rd_word;
    logic [WB_DW-1:0] rd_ctrl;
    logic [WB_DW-1:0] rd_status;
    logic [CH_W-1:0]  rd_ch;
    logic [CH_W-1:0]  wr_ch;
    logic [CTRL_W-1:0] ctrl_q [NUM_CH];

    wb_slave_frontend #(
        .ADR_W (ADR_W)
    ) u_frontend (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .cyc     (wb_cyc_i),
        .stb     (wb_stb_i),
        .we      (wb_we_i),
        .adr     (wb_adr_i),
        .sel     (wb_sel_i),
        .wdata   (wb_dat_i),
        .rd_hit  (rd_hit),
        .rd_word (rd_word),
        .wr_hit  (wr_hit),
        .rd_req  (rd_req),
        .wr_pend (wr_pend),
        .wr_adr  (wr_adr),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .ack     (wb_ack_o),
        .err     (wb_err_o),
        .stall   (wb_stall_o),
        .rdata   (wb_dat_o)
    );

    assign wb_rty_o = 1'b0;

    // A single channel has no channel-index bits in the address
    if (ADR_W > 1) begin : g_ch_idx
        assign rd_ch = wb_adr_i[ADR_W+1:3];
        assign wr_ch = wr_adr[ADR_W-1:1];
    end else begin : g_ch_idx_single
        assign rd_ch = 1'b0;
        assign wr_ch = 1'b0;
    end

    // Read decode uses the live address; write decode uses the registered one
    assign rd_hit = int'(rd_ch) < NUM_CH;
    assign wr_hit = (int'(wr_ch) < NUM_CH) && (wr_adr[0] == CTRL_OFS);

    always_comb begin
        rd_ctrl   = '0;
        rd_status = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(rd_ch) == k) begin
                rd_ctrl[CTRL_W-1:0] = ctrl_q[k];
                rd_status           = status_i[k*WB_DW +: WB_DW];
            end
        end
    end

    assign rd_word = (wb_adr_i[2] == STATUS_OFS) ? rd_status : rd_ctrl;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [WB_DW-1:0]  old_word;
        logic [CTRL_W-1:0] merged;
        logic [CTRL_W-1:0] ctrl_reg;
        logic              pulse_reg;
        logic              wr_this;

        always_comb begin
            old_word             = '0;
            old_word[CTRL_W-1:0] = ctrl_reg;
        end

        assign merged  = CTRL_W'(byte_merge(old_word, wr_data, wr_sel));
        assign wr_this = wr_pend & wr_hit & (int'(wr_ch) == k) & (|wr_sel);

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                ctrl_reg  <= CTRL_RST[CTRL_W-1:0];
                pulse_reg <= 1'b0;
            end else begin
                pulse_reg <= wr_this;
                if (wr_this) begin
                    ctrl_reg <= merged;
                end
            end
        end

        assign ctrl_q[k]                   = ctrl_reg;
        assign ctrl_o[k*CTRL_W +: CTRL_W]  = ctrl_reg;
        assign ctrl_wr_o[k]                = pulse_reg;
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_repeat_regbank.sv
`default_nettype none
// ============================================================================
// tb_wb_repeat_regbank : two bank configurations on one shared Wishbone bus
// Rev 1.0
// ============================================================================
module tb_wb_repeat_regbank;

    localparam int          NCH_A = 4;
    localparam int          CW_A  = 8;
    localparam logic [31:0] RST_A = 32'h0000_005A;
    localparam int          NCH_B = 3;
    localparam int          CW_B  = 32;
    localparam logic [31:0] RST_B = 32'h0;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc   = 1'b0;
    logic        stb   = 1'b0;
    logic        we    = 1'b0;
    logic [4:2]  adr   = '0;
    logic [3:0]  sel   = '0;
    logic [31:0] dat   = '0;

    logic                    ack_a, err_a, rty_a, stall_a;
    logic [31:0]             rdat_a;
    logic [NCH_A*CW_A-1:0]   ctrl_a;
    logic [NCH_A-1:0]        cwr_a;
    logic [NCH_A*32-1:0]     stat_a = '0;

    logic                    ack_b, err_b, rty_b, stall_b;
    logic [31:0]             rdat_b;
    logic [NCH_B*CW_B-1:0]   ctrl_b;
    logic [NCH_B-1:0]        cwr_b;
    logic [NCH_B*32-1:0]     stat_b = '0;

    always #5 clk = ~clk;

    wb_repeat_regbank #(.NUM_CH(NCH_A), .CTRL_W(CW_A), .CTRL_RST(RST_A)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_adr_i(adr),
        .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(dat), .wb_ack_o(ack_a), .wb_err_o(err_a),
        .wb_rty_o(rty_a), .wb_stall_o(stall_a), .wb_dat_o(rdat_a), .ctrl_o(ctrl_a),
        .ctrl_wr_o(cwr_a), .status_i(stat_a)
    );

    wb_repeat_regbank #(.NUM_CH(NCH_B), .CTRL_W(CW_B), .CTRL_RST(RST_B)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_adr_i(adr),
        .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(dat), .wb_ack_o(ack_b), .wb_err_o(err_b),
        .wb_rty_o(rty_b), .wb_stall_o(stall_b), .wb_dat_o(rdat_b), .ctrl_o(ctrl_b),
        .ctrl_wr_o(cwr_b), .status_i(stat_b)
    );

    // Reference model: index 0 is bank A, index 1 is bank B
    int          nch   [2] = '{NCH_A, NCH_B};
    int          cw    [2] = '{CW_A, CW_B};
    logic [31:0] crst  [2] = '{RST_A, RST_B};
    logic [31:0] m_ctrl[2][16];
    logic [31:0] m_stat[2][4];
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [4:0]  badr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        ea;
        logic [31:0] ra;
        logic        eb;
        logic [31:0] rb;
    } vec_t;
    vec_t tbl[14];

    function automatic logic [31:0] cmask(input int dd);
        return (cw[dd] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cw[dd]) - 32'd1);
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 16; k++)
                m_ctrl[d][k] = crst[d] & cmask(d);
    endfunction

    function automatic void predict(input int dd, input logic w, input logic [4:0] badr,
                                    output logic e, output logic [31:0] r);
        int ch;
        ch = int'(badr[4:3]);
        if (ch >= nch[dd] || (w && badr[2])) begin
            e = 1'b1;
            r = 32'h0;
        end else begin
            e = 1'b0;
            r = badr[2] ? m_stat[dd][ch] : m_ctrl[dd][ch];
        end
    endfunction

    function automatic void model_write(input int dd, input logic w, input logic [4:0] badr,
                                        input logic [31:0] d, input logic [3:0] s,
                                        output logic [3:0] pulse);
        int ch;
        logic [31:0] v;
        ch    = int'(badr[4:3]);
        pulse = '0;
        if (w && !badr[2] && ch < nch[dd] && s != 4'h0) begin
            v = m_ctrl[dd][ch];
            for (int b = 0; b < 4; b++)
                if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
            m_ctrl[dd][ch] = v & cmask(dd);
            pulse[ch] = 1'b1;
        end
    endfunction

    function automatic logic [NCH_A*CW_A-1:0] flat_a();
        logic [NCH_A*CW_A-1:0] r;
        for (int k = 0; k < NCH_A; k++) r[k*CW_A +: CW_A] = m_ctrl[0][k][CW_A-1:0];
        return r;
    endfunction

    function automatic logic [NCH_B*CW_B-1:0] flat_b();
        logic [NCH_B*CW_B-1:0] r;
        for (int k = 0; k < NCH_B; k++) r[k*CW_B +: CW_B] = m_ctrl[1][k][CW_B-1:0];
        return r;
    endfunction

    task automatic apply_status();
        for (int k = 0; k < NCH_A; k++) stat_a[k*32 +: 32] = m_stat[0][k];
        for (int k = 0; k < NCH_B; k++) stat_b[k*32 +: 32] = m_stat[1][k];
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request: strobe in N, termination in N+1, strobe dropped, effects in N+2
    task automatic txn(input logic w, input logic [4:0] badr, input logic [31:0] d,
                       input logic [3:0] s, input logic ea, input logic [31:0] ra,
                       input logic eb, input logic [31:0] rb, input bit perturb);
        logic [3:0] pa, pb;
        model_write(0, w, badr, d, s, pa);
        model_write(1, w, badr, d, s, pb);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = badr[4:2]; sel = s; dat = d;
        #1;
        chk("stall_req_a", stall_a, 1'b1);
        chk("stall_req_b", stall_b, 1'b1);
        chk("early_term_a", {ack_a, err_a}, 2'b00);
        chk("early_term_b", {ack_b, err_b}, 2'b00);
        chk("pulse_quiet_a", cwr_a, 4'h0);
        chk("pulse_quiet_b", cwr_b, 3'h0);
        @(negedge clk);
        if (perturb && !w) begin
            for (int k = 0; k < 4; k++) begin
                m_stat[0][k] = $urandom;
                m_stat[1][k] = $urandom;
            end
            apply_status();
        end
        chk("term_a", {ack_a, err_a}, ea ? 2'b01 : 2'b10);
        chk("term_b", {ack_b, err_b}, eb ? 2'b01 : 2'b10);
        chk("stall_term_a", stall_a, 1'b0);
        chk("stall_term_b", stall_b, 1'b0);
        if (!w) begin
            chk("rdat_a", rdat_a, ra);
            chk("rdat_b", rdat_b, rb);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        chk("idle_a", {ack_a, err_a}, 2'b00);
        chk("idle_b", {ack_b, err_b}, 2'b00);
        chk("pulse_a", cwr_a, pa);
        chk("pulse_b", cwr_b, pb);
        chk("ctrl_a", ctrl_a, flat_a());
        chk("ctrl_b", ctrl_b, flat_b());
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if ((ack_a & err_a) | (ack_b & err_b) | rty_a | rty_b) begin
                bad++;
                $display("FAIL term_excl: ack_a=%b err_a=%b ack_b=%b err_b=%b rty=%b%b",
                         ack_a, err_a, ack_b, err_b, rty_a, rty_b);
            end
        end
    end

    initial begin
        logic        w, ea, eb;
        logic [4:0]  badr;
        logic [31:0] d, ra, rb;
        logic [3:0]  s, pa, pb;

        tbl[0]  = '{1'b0, 5'h00, 32'h0,         4'hF, 1'b0, 32'h0000_005A, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 5'h10, 32'hDEAD_BEEF, 4'h5, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[2]  = '{1'b0, 5'h10, 32'h0,         4'hF, 1'b0, 32'h0000_00EF, 1'b0, 32'h00AD_00EF};
        tbl[3]  = '{1'b1, 5'h0C, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0,         1'b1, 32'h0};
        tbl[4]  = '{1'b1, 5'h08, 32'h1111_1111, 4'h0, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[5]  = '{1'b0, 5'h18, 32'h0,         4'hF, 1'b0, 32'h0000_005A, 1'b1, 32'h0};
        tbl[6]  = '{1'b0, 5'h04, 32'h0,         4'hF, 1'b0, 32'hA000_0000, 1'b0, 32'h1234_5678};
        tbl[7]  = '{1'b0, 5'h1C, 32'h0,         4'hF, 1'b0, 32'hA000_0003, 1'b1, 32'h0};
        tbl[8]  = '{1'b1, 5'h18, 32'h1234_5678, 4'hF, 1'b0, 32'h0,         1'b1, 32'h0};
        tbl[9]  = '{1'b0, 5'h18, 32'h0,         4'hF, 1'b0, 32'h0000_0078, 1'b1, 32'h0};
        tbl[10] = '{1'b0, 5'h08, 32'h0,         4'hF, 1'b0, 32'h0000_005A, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 5'h00, 32'hCAFE_F00D, 4'h8, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[12] = '{1'b0, 5'h00, 32'h0,         4'hF, 1'b0, 32'h0000_005A, 1'b0, 32'hCA00_0000};
        tbl[13] = '{1'b0, 5'h0C, 32'h0,         4'hF, 1'b0, 32'hA000_0001, 1'b0, 32'h0000_00B1};

        model_reset();
        for (int k = 0; k < 4; k++) m_stat[0][k] = 32'hA000_0000 + 32'(k);
        m_stat[1][0] = 32'h1234_5678;
        m_stat[1][1] = 32'h0000_00B1;
        m_stat[1][2] = 32'h0000_00B2;
        m_stat[1][3] = 32'h0;
        apply_status();

        repeat (2) @(negedge clk);
        chk("rst_ctrl_a", ctrl_a, {4{8'h5A}});
        chk("rst_ctrl_b", ctrl_b, 96'h0);
        chk("rst_term_a", {ack_a, err_a}, 2'b00);
        chk("rst_term_b", {ack_b, err_b}, 2'b00);
        chk("rst_dat_a", rdat_a, 32'h0);
        chk("rst_pulse_a", cwr_a, 4'h0);
        chk("rst_pulse_b", cwr_b, 3'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            txn(tbl[i].we, tbl[i].badr, tbl[i].dat, tbl[i].sel,
                tbl[i].ea, tbl[i].ra, tbl[i].eb, tbl[i].rb, 1'b0);

        // Read held under stall immediately followed by a write
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 3'b001; sel = 4'hF;
        @(negedge clk);
        chk("b2b_rd_term_a", {ack_a, err_a}, 2'b10);
        chk("b2b_rd_term_b", {ack_b, err_b}, 2'b10);
        chk("b2b_rd_dat_a", rdat_a, m_stat[0][0]);
        chk("b2b_rd_dat_b", rdat_b, m_stat[1][0]);
        we = 1'b1; adr = 3'b000; dat = 32'h0000_00C3; sel = 4'h1;
        model_write(0, 1'b1, 5'h00, 32'h0000_00C3, 4'h1, pa);
        model_write(1, 1'b1, 5'h00, 32'h0000_00C3, 4'h1, pb);
        @(negedge clk);
        chk("b2b_wr_term_a", {ack_a, err_a}, 2'b10);
        chk("b2b_wr_term_b", {ack_b, err_b}, 2'b10);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        chk("b2b_idle_a", {ack_a, err_a}, 2'b00);
        chk("b2b_pulse_a", cwr_a, pa);
        chk("b2b_pulse_b", cwr_b, pb);
        chk("b2b_ctrl_a", ctrl_a, flat_a());
        chk("b2b_ctrl_b", ctrl_b, flat_b());

        // Reset arriving in the cycle after a write strobe
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'b100; dat = 32'h3333_3333; sel = 4'hF;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl_a", ctrl_a, {4{8'h5A}});
        chk("rst_mid_ctrl_b", ctrl_b, 96'h0);
        chk("rst_mid_term_a", {ack_a, err_a}, 2'b00);
        chk("rst_mid_term_b", {ack_b, err_b}, 2'b00);
        chk("rst_mid_pulse_a", cwr_a, 4'h0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rst_after_term_a", {ack_a, err_a}, 2'b00);
        chk("rst_after_term_b", {ack_b, err_b}, 2'b00);
        chk("rst_after_pulse_b", cwr_b, 3'h0);
        chk("rst_after_ctrl_b", ctrl_b, flat_b());

        for (int i = 0; i < 200; i++) begin
            w    = 1'($urandom_range(0, 1));
            badr = {3'($urandom_range(0, 7)), 2'b00};
            d    = $urandom;
            s    = 4'($urandom_range(0, 15));
            predict(0, w, badr, ea, ra);
            predict(1, w, badr, eb, rb);
            txn(w, badr, d, s, ea, ra, eb, rb, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_repeat_regbank.md
Name: wb_repeat_regbank

Overview:
Parametrised Wishbone (classic-pipelined, 32-bit) register bank with NUM_CH repeated channels.
- Each channel has one RW control register (byte-lane writes, per-channel reset value) and one RO status word.
- A write to a control register produces a one-cycle strobe to user logic.
- Unmapped or illegal accesses terminate with wb_err_o instead of wb_ack_o.
- Sits between the Wishbone interconnect and per-channel user logic, as the generalised form of fixed-count repeated register blocks.

Parameters:
NUM_CH, 4, number of channels; 1..16.
CTRL_W, 32, implemented control bits per channel; 1..32; bits [31:CTRL_W] read 0 and ignore writes.
CTRL_RST, 0, control register reset value, common to all channels; only [CTRL_W-1:0] used.
ADR_W, clog2(NUM_CH)+1, word-address bits; derived, not overridable.

Ports:
clk_i  in  1  single clock, rising edge
rst_n_i  in  1  reset, asynchronous assert, active-low
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_adr_i  in  [ADR_W+1:2]  word address; bit 2 = register select (0 ctrl, 1 status); upper bits = channel index
wb_sel_i  in  4  byte lanes
wb_we_i  in  1  write enable
wb_dat_i  in  32  write data
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination
wb_rty_o  out  1  tied 0
wb_stall_o  out  1  ~(ack|err) & cyc & stb
wb_dat_o  out  32  read data, registered
ctrl_o  out  NUM_CH*CTRL_W  flattened control registers, channel k at [k*CTRL_W +: CTRL_W]
ctrl_wr_o  out  NUM_CH  one-cycle pulse per channel on effective control write
status_i  in  NUM_CH*32  flattened status words, channel k at [k*32 +: 32]

Behaviour:
- Reset (asynchronous, rst_n_i=0):
  - ctrl_o = CTRL_RST per channel.
  - ctrl_wr_o, wb_ack_o, wb_err_o = 0; wb_dat_o = 0.
  - Request-in-progress flags and pipeline registers cleared.
  - Deassertion is used synchronously via the clock; no synchronizer inside.
- Request generation:
  - en = cyc & stb.
  - rd_req = en & ~we & ~rip; wr_req = en & we & ~wip.
  - rip and wip are set on request and cleared on the cycle their termination (ack or err) is asserted. This gives exactly one request per strobe held under stall.
- Write path:
  - Cycle N: wr_req, address, data and sel are registered.
  - Cycle N+1: decode from registered values; termination (ack or err) is driven combinationally in N+1.
  - Control register and ctrl_wr_o update at the N+1 clock edge, so they are visible from N+2.
  - Latency: termination exactly 1 cycle after the accepted strobe.
- Write to ctrl of channel k < NUM_CH:
  - Bytes with sel=1 are written; bits >= CTRL_W are discarded.
  - ctrl_wr_o[k] pulses for one cycle only if sel != 0.
  - A write with sel=0 is acked and changes nothing.
- Write to status, or to channel index >= NUM_CH: wb_err_o, no state change, no pulse.
- Read path:
  - Cycle N: decode is combinational from live wb_adr_i.
  - Data and termination are registered; ack or err is asserted in N+1 with wb_dat_o valid.
  - status_i is sampled in cycle N, not re-sampled later.
- Read data:
  - ctrl: zero-extended from CTRL_W.
  - status: status_i word.
  - Unmapped read: wb_err_o, wb_dat_o = 0.
- Termination rules:
  - ack and err are mutually exclusive and each lasts one cycle.
  - A read and a write termination never coincide, because the master issues one outstanding request.
- Deassertions:
  - cyc dropped after a request is accepted: the pending termination still fires and is ignored by the master. Any write still commits.
  - Reset mid-transaction: the transaction is lost, no termination follows, and the master must retry.
- Non-power-of-two NUM_CH: decodes for unused channel indices return err.

Decomposition:
- Package wb_regbank_pkg:
  - constants: CTRL_OFS=0, STATUS_OFS=1 (word-select values), WB_DW=32.
  - function clog2.
  - function byte_merge(old, new, sel).
- Sub-module wb_slave_frontend: rip/wip tracking, rd/wr request generation, write-side pipeline register, ack/err/stall muxing.
- The register array and decode stay in the top level as generate loops over NUM_CH.

Test Plan:
- Reset with CTRL_RST=0x5A, CTRL_W=8, NUM_CH=4 -> all ctrl_o lanes = 0x5A; a read at 0x00 returns 0x0000005A, ack 1 cycle after stb.
- Write 0xDEADBEEF to channel 2 ctrl (byte addr 0x10), sel=0b0101, CTRL_W=32, previous value 0 -> ctrl_o ch2 = 0x00AD00EF, ctrl_wr_o = 0b0100 for exactly one cycle, ack at N+1, stall high in N only.
- Write to channel 1 status (0x0C) -> err at N+1, no ack, ctrl unchanged, no ctrl_wr_o pulse; a write with sel=0 to 0x08 -> ack, no pulse.
- NUM_CH=3, read at 0x18 (channel 3) -> err, wb_dat_o = 0; read of status ch0 with status_i = 0x12345678 -> wb_dat_o = 0x12345678.
- Back-to-back: hold stb through stall for a read, then a write -> exactly one termination per request, never simultaneous ack/err.
- Assert rst_n_i in the cycle after a write strobe -> no ack, ctrl_o = CTRL_RST immediately (asynchronously), no pulse.
